md_unit_ctrl: RTL and testbench
===============================

# md_unit_ctrl

Multi-cycle multiply/divide sequencer that sits beside the EX-stage ALU in the pipelined CPU. It owns the HI/LO architectural registers and runs mult/multu/div/divu over a fixed number of cycles. It exposes a Busy flag that the hazard unit combines with Start to stall any later multiply/divide instruction or HI/LO access. It also performs the single-cycle mthi/mtlo writes.

## Interface
- MULT_CYC, 5, cycles Busy stays high for mult/multu (≥1)
- DIV_CYC, 10, cycles Busy stays high for div/divu (≥1)

- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  one clock; reset is synchronous and active-low
- Start  input  1  EX-stage instruction is a valid mult/multu/div/divu/mthi/mtlo this cycle
- MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- In0  input  32  rs operand (multiplicand / dividend / mthi-mtlo data)
- In1  input  32  rt operand (multiplier / divisor)
- Busy  output  1  operation in progress; registered
- HI  output  32  HI register; registered
- LO  output  32  LO register; registered

## Operation
- States: IDLE, MUL, DIV. Reset (rst_n=0 at an edge) → IDLE, Busy=0, HI=0, LO=0, counter=0, shadow regs=0; overrides everything, including an op in flight (result discarded).
- IDLE with Start=1:
  - MDOp 1/2 → compute the 64-bit product into shadow {SH,SL}, signed (1) or unsigned (2). Load counter=MULT_CYC, go MUL.
  - MDOp 3/4 → quotient→SL, remainder→SH, signed (3) or unsigned (4). Load counter=DIV_CYC, go DIV.
  - MDOp 5 → HI<=In0; MDOp 6 → LO<=In0. Takes effect at the same edge; stay IDLE; Busy stays 0.
  - MDOp 0/7 → no effect.
- Signed divide:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → SL=0x80000000, SH=0.
- Divide by zero (In1=0, div or divu): enter DIV and hold Busy normally, but HI/LO are left unchanged at completion.
- MUL/DIV: counter decrements each edge. At the edge where counter==1: HI<=SH, LO<=SL, Busy<=0, go IDLE.
- Start=1 while Busy=1 (any MDOp) is ignored. The hazard unit guarantees stalls; the block must not corrupt shadow, counter or HI/LO.
- HI/LO change only at a completion edge, an mthi/mtlo edge, or reset.

## Timing
- Start sampled at edge T → Busy=1 from after T through edge T+N, where N=MULT_CYC or DIV_CYC.
- At edge T+N: HI/LO updated and Busy=0 simultaneously. Busy is high for exactly N cycles.
- A new Start is accepted at edge T+N+1 at the earliest, i.e. in the first cycle in which Busy reads 0. Back-to-back ops therefore have N+1 cycle spacing.
- mthi/mtlo: HI/LO visible the cycle after the Start edge; zero Busy cycles.
- Stall rule for the hazard unit (external): stall when (Busy | Start) and the D-stage instruction is an MD op or mfhi/mflo. The block itself exposes only the registered Busy.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold rst_n=0 two edges with Start=1, MDOp=1 → Busy=0, HI=0, LO=0. Release, then mthi 0x12345678 → HI=0x12345678 next cycle, Busy never rises.
- mult vs multu: In0=0xFFFFFFFF, In1=2.
  - mult → Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - multu → HI=0x00000001, LO=0xFFFFFFFE.
- div signed/unsigned and overflow:
  - div In0=0xFFFFFFF9 (−7), In1=2 → after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7/2 → LO=3, HI=1.
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: preload HI=0xAAAA0000, LO=0x5555 via mthi/mtlo. divu In1=0 → Busy high 10 cycles, HI/LO unchanged.
- Start during Busy: mult 3×4, then in cycle 2 of Busy assert Start with div 100/7 and with mtlo 0xDEAD → ignored. Final HI=0, LO=12, Busy low after 5 cycles total.
- Reset mid-op: div 100/7, drop rst_n at Busy cycle 4 → next cycle Busy=0, HI=LO=0. A subsequent multu 6×7 gives LO=42, HI=0 after 5 cycles.

Source files
------------

// File: rtl/md_unit_ctrl_if.sv
// md_unit_ctrl_if: handshake/operand bundle between EX stage and the multiply/divide sequencer
// master: drives i_start, i_md_op, i_in0, i_in1; observes o_busy, o_hi, o_lo
// slave : the sequencer side of the same signals
interface md_unit_ctrl_if;
    logic        i_start;
    logic [2:0]  i_md_op;
    logic [31:0] i_in0;
    logic [31:0] i_in1;
    logic        o_busy;
    logic [31:0] o_hi;
    logic [31:0] o_lo;
    modport master (output i_start, i_md_op, i_in0, i_in1, input o_busy, o_hi, o_lo);
    modport slave  (input i_start, i_md_op, i_in0, i_in1, output o_busy, o_hi, o_lo);
endinterface

// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle mult/multu/div/divu sequencer owning HI/LO, plus single-cycle mthi/mtlo
// clk   : rising-edge clock
// rst_n : synchronous active-low reset
// md    : i_start/i_md_op/i_in0/i_in1 request, o_busy/o_hi/o_lo registered results
module md_unit_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input logic         clk,
    input logic         rst_n,
    md_unit_ctrl_if.slave md
);
    localparam int MAXC = MULT_CYC > DIV_CYC ? MULT_CYC : DIV_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
    state_t             r_state, w_state_n;
    logic [CW-1:0]      r_cnt, w_cnt_n;
    logic [31:0]        r_sh, r_sl, r_hi, r_lo;
    logic [31:0]        w_sh_n, w_sl_n, w_hi_n, w_lo_n;
    logic               r_dz, w_dz_n, r_busy;
    logic [63:0]        w_prod_s, w_prod_u;
    logic               w_neg1;
    logic [31:0]        w_ds, w_du, w_uq, w_ur;
    logic signed [31:0] w_sq, w_sr;
    assign w_prod_s = $signed({{32{md.i_in0[31]}}, md.i_in0}) * $signed({{32{md.i_in1[31]}}, md.i_in1});
    assign w_prod_u = {32'd0, md.i_in0} * {32'd0, md.i_in1};
    // Divisors are forced non-zero so the dividers never see x/0; a divisor of -1
    // is handled by negation so INT_MIN / -1 wraps to INT_MIN with remainder 0.
    assign w_neg1 = md.i_in1 == 32'hFFFF_FFFF;
    assign w_ds   = (md.i_in1 == '0 || w_neg1) ? 32'd1 : md.i_in1;
    assign w_du   = md.i_in1 == '0 ? 32'd1 : md.i_in1;
    assign w_sq   = $signed(md.i_in0) / $signed(w_ds);
    assign w_sr   = $signed(md.i_in0) % $signed(w_ds);
    assign w_uq   = md.i_in0 / w_du;
    assign w_ur   = md.i_in0 % w_du;
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_sh_n    = r_sh;
        w_sl_n    = r_sl;
        w_hi_n    = r_hi;
        w_lo_n    = r_lo;
        w_dz_n    = r_dz;
        if (r_state == IDLE) begin
            if (md.i_start) begin
                if (md.i_md_op == 3'd1 || md.i_md_op == 3'd2) begin
                    {w_sh_n, w_sl_n} = md.i_md_op == 3'd1 ? w_prod_s : w_prod_u;
                    w_cnt_n   = CW'(MULT_CYC);
                    w_dz_n    = 1'b0;
                    w_state_n = MUL;
                end else if (md.i_md_op == 3'd3 || md.i_md_op == 3'd4) begin
                    w_sl_n    = md.i_md_op == 3'd4 ? w_uq : (w_neg1 ? 32'd0 - md.i_in0 : w_sq);
                    w_sh_n    = md.i_md_op == 3'd4 ? w_ur : (w_neg1 ? 32'd0 : w_sr);
                    w_cnt_n   = CW'(DIV_CYC);
                    w_dz_n    = md.i_in1 == '0;
                    w_state_n = DIV;
                end else if (md.i_md_op == 3'd5) begin
                    w_hi_n = md.i_in0;
                end else if (md.i_md_op == 3'd6) begin
                    w_lo_n = md.i_in0;
                end
            end
        end else begin
            w_cnt_n = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                w_state_n = IDLE;
                w_hi_n    = r_dz ? r_hi : r_sh;
                w_lo_n    = r_dz ? r_lo : r_sl;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_sl    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_sh    <= w_sh_n;
            r_sl    <= w_sl_n;
            r_hi    <= w_hi_n;
            r_lo    <= w_lo_n;
            r_dz    <= w_dz_n;
            r_busy  <= w_state_n != IDLE;
        end
    end
    assign md.o_busy = r_busy;
    assign md.o_hi   = r_hi;
    assign md.o_lo   = r_lo;
endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed and randomized checks of md_unit_ctrl against an arithmetic reference model
// drives the interface master side; clk/rst_n generated locally
module tb_md_unit_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] mh = '0;
    logic [31:0] ml = '0;
    md_unit_ctrl_if m();
    md_unit_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (.clk(clk), .rst_n(rst_n), .md(m));
    always #5 clk = ~clk;

    // Reference: HI/LO after an accepted op, and how many cycles Busy should read high.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        longint p, q, r;
        n = 0;
        if (op == 3'd1 || op == 3'd2) begin
            p = op == 3'd1 ? longint'($signed(a)) * longint'($signed(b)) : longint'({32'd0, a}) * longint'({32'd0, b});
            mh = p[63:32];
            ml = p[31:0];
            n = 5;
        end else if (op == 3'd3 || op == 3'd4) begin
            n = 10;
            if (b != 0) begin
                q = op == 3'd3 ? longint'($signed(a)) / longint'($signed(b)) : longint'({32'd0, a}) / longint'({32'd0, b});
                r = op == 3'd3 ? longint'($signed(a)) % longint'($signed(b)) : longint'({32'd0, a}) % longint'({32'd0, b});
                ml = q[31:0];
                mh = r[31:0];
            end
        end else if (op == 3'd5) begin
            mh = a;
        end else if (op == 3'd6) begin
            ml = a;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int bc, output int n);
        model_op(op, a, b, n);
        @(negedge clk);
        m.i_start = 1'b1;
        m.i_md_op = op;
        m.i_in0   = a;
        m.i_in1   = b;
        @(negedge clk);
        m.i_start = 1'b0;
        m.i_md_op = 3'd0;
        bc = 0;
        while (m.o_busy === 1'b1 && bc < 64) begin
            bc++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] pick();
        int s;
        s = int'($urandom_range(0, 5));
        return s == 0 ? 32'd0 : s == 1 ? 32'hFFFF_FFFF : s == 2 ? 32'h8000_0000 :
               s == 3 ? 32'($urandom_range(0, 20)) : 32'($urandom);
    endfunction

    task automatic test_reset();
        int bc, n;
        m.i_start = 1'b1;
        m.i_md_op = 3'd1;
        m.i_in0   = 32'd9;
        m.i_in1   = 32'd9;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (m.o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", m.o_busy); end
        total++; if (m.o_hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", m.o_hi); end
        total++; if (m.o_lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", m.o_lo); end
        m.i_start = 1'b0;
        m.i_md_op = 3'd0;
        rst_n     = 1'b1;
        mh = '0;
        ml = '0;
        run_op(3'd5, 32'h1234_5678, 32'd0, bc, n);
        total++; if (bc !== 0) begin bad++; $display("FAIL mthi_busy got=%0d exp=0", bc); end
        total++; if (m.o_hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi_hi got=%h exp=12345678", m.o_hi); end
    endtask

    task automatic test_mult();
        int bc, n;
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, bc, n);
        total++; if (bc !== 5) begin bad++; $display("FAIL mult_busy got=%0d exp=5", bc); end
        total++; if (m.o_hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", m.o_hi); end
        total++; if (m.o_lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffe", m.o_lo); end
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, bc, n);
        total++; if (m.o_hi !== 32'h0000_0001) begin bad++; $display("FAIL multu_hi got=%h exp=00000001", m.o_hi); end
        total++; if (m.o_lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_lo got=%h exp=fffffffe", m.o_lo); end
    endtask

    task automatic test_div();
        int bc, n;
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, bc, n);
        total++; if (bc !== 10) begin bad++; $display("FAIL div_busy got=%0d exp=10", bc); end
        total++; if (m.o_lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", m.o_lo); end
        total++; if (m.o_hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", m.o_hi); end
        run_op(3'd4, 32'd7, 32'd2, bc, n);
        total++; if (m.o_lo !== 32'd3) begin bad++; $display("FAIL divu_lo got=%h exp=3", m.o_lo); end
        total++; if (m.o_hi !== 32'd1) begin bad++; $display("FAIL divu_hi got=%h exp=1", m.o_hi); end
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, bc, n);
        total++; if (m.o_lo !== 32'h8000_0000) begin bad++; $display("FAIL divovf_lo got=%h exp=80000000", m.o_lo); end
        total++; if (m.o_hi !== 32'd0) begin bad++; $display("FAIL divovf_hi got=%h exp=0", m.o_hi); end
    endtask

    task automatic test_div_zero();
        int bc, n;
        run_op(3'd5, 32'hAAAA_0000, 32'd0, bc, n);
        run_op(3'd6, 32'h0000_5555, 32'd0, bc, n);
        run_op(3'd4, 32'd1234, 32'd0, bc, n);
        total++; if (bc !== 10) begin bad++; $display("FAIL divz_busy got=%0d exp=10", bc); end
        total++; if (m.o_hi !== 32'hAAAA_0000) begin bad++; $display("FAIL divz_hi got=%h exp=aaaa0000", m.o_hi); end
        total++; if (m.o_lo !== 32'h0000_5555) begin bad++; $display("FAIL divz_lo got=%h exp=00005555", m.o_lo); end
    endtask

    task automatic test_start_busy();
        int bc, n;
        model_op(3'd1, 32'd3, 32'd4, n);
        @(negedge clk);
        m.i_start = 1'b1;
        m.i_md_op = 3'd1;
        m.i_in0   = 32'd3;
        m.i_in1   = 32'd4;
        bc = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (m.o_busy !== 1'b1) break;
            bc++;
            m.i_start = i == 1 || i == 2;
            m.i_md_op = i == 1 ? 3'd3 : i == 2 ? 3'd6 : 3'd0;
            m.i_in0   = i == 1 ? 32'd100 : 32'h0000_DEAD;
            m.i_in1   = 32'd7;
        end
        m.i_start = 1'b0;
        total++; if (bc !== 5) begin bad++; $display("FAIL busy_ign_cycles got=%0d exp=5", bc); end
        total++; if (m.o_hi !== 32'd0) begin bad++; $display("FAIL busy_ign_hi got=%h exp=0", m.o_hi); end
        total++; if (m.o_lo !== 32'd12) begin bad++; $display("FAIL busy_ign_lo got=%h exp=c", m.o_lo); end
    endtask

    task automatic test_reset_mid();
        int bc, n;
        @(negedge clk);
        m.i_start = 1'b1;
        m.i_md_op = 3'd3;
        m.i_in0   = 32'd100;
        m.i_in1   = 32'd7;
        @(negedge clk);
        m.i_start = 1'b0;
        m.i_md_op = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mh = '0;
        ml = '0;
        total++; if (m.o_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", m.o_busy); end
        total++; if (m.o_hi !== 32'd0 || m.o_lo !== 32'd0) begin bad++; $display("FAIL midrst_hilo got=%h/%h exp=0/0", m.o_hi, m.o_lo); end
        run_op(3'd2, 32'd6, 32'd7, bc, n);
        total++; if (bc !== 5) begin bad++; $display("FAIL midrst_mul_busy got=%0d exp=5", bc); end
        total++; if (m.o_lo !== 32'd42 || m.o_hi !== 32'd0) begin bad++; $display("FAIL midrst_mul got=%h/%h exp=0/2a", m.o_hi, m.o_lo); end
    endtask

    task automatic test_random();
        int bc, n;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op(op, a, b, bc, n);
            total++; if (bc !== n) begin bad++; $display("FAIL rnd_busy op=%0d a=%h b=%h got=%0d exp=%0d", op, a, b, bc, n); end
            total++; if (m.o_hi !== mh) begin bad++; $display("FAIL rnd_hi op=%0d a=%h b=%h got=%h exp=%h", op, a, b, m.o_hi, mh); end
            total++; if (m.o_lo !== ml) begin bad++; $display("FAIL rnd_lo op=%0d a=%h b=%h got=%h exp=%h", op, a, b, m.o_lo, ml); end
        end
    endtask

    initial begin
        m.i_start = 1'b0;
        m.i_md_op = 3'd0;
        m.i_in0   = '0;
        m.i_in1   = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
